// File: rtl/zap_divide_pkg.sv
// -----------------------------------------------------------------------------
// zap_divide_pkg
// Shared definitions for the iterative divider in the shifter stage.
//   - ALU opcode constants for the multiply/divide group. The divider only
//     decodes OP_UDIV and OP_SDIV; the multiply codes are listed so both units
//     share one opcode map.
//   - Divider FSM state encoding.
//   - magnitude(): two's-complement absolute value with natural 32-bit wrap,
//     so 0x80000000 maps to 0x80000000 (read as unsigned 2^31).
// -----------------------------------------------------------------------------
package zap_divide_pkg;

    // Multiply/divide opcode group (5-bit opcode space, 32 ALU operations)
    localparam int OP_MUL   = 16;
    localparam int OP_MLA   = 17;
    localparam int OP_UMULL = 18;
    localparam int OP_UMLAL = 19;
    localparam int OP_SMULL = 20;
    localparam int OP_SMLAL = 21;
    localparam int OP_UDIV  = 22;
    localparam int OP_SDIV  = 23;

    localparam int DIV_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } div_state_t;

    function automatic logic [DIV_W-1:0] magnitude(input logic signed [DIV_W-1:0] v);
        logic signed [DIV_W-1:0] neg_v;
        neg_v = -v;
        return v[DIV_W-1] ? DIV_W'(neg_v) : DIV_W'(v);
    endfunction

endpackage

// File: rtl/zap_divide_clz32.sv
// -----------------------------------------------------------------------------
// zap_clz32
// Combinational leading-zero counter for a 32-bit word. Only instantiated by
// zap_divide when ZAP_DIV_EARLY_TERM_EN is defined.
// Ports:
//   value  in  32  word to scan
//   count  out 6   number of leading zeros, 0..32 (32 when value == 0)
// -----------------------------------------------------------------------------
module zap_clz32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scan LSB to MSB so the highest set bit is the last one to write count.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/zap_divide.sv
// -----------------------------------------------------------------------------
// zap_divide
// Iterative 32/32 restoring divider, one quotient bit per cycle. Shares the
// multiplier's control interface in the shifter stage. Decodes UDIV and SDIV
// (signed, rounds toward zero). Divide by zero returns 0 without trapping.
//
// Optional build macro: ZAP_DIV_EARLY_TERM_EN
//   When defined, INIT pre-normalises the dividend by its leading-zero count
//   so only the significant bits are iterated; a zero dividend skips ITER.
//   When undefined, every non-zero-divisor op runs 32 ITER cycles and no
//   leading-zero logic exists.
//
// Ports:
//   i_clk                   in  1    clock
//   i_reset_n               in  1    synchronous active-low reset
//   i_clear_from_writeback  in  1    flush, wins over stall
//   i_data_stall            in  1    hold all state
//   i_clear_from_alu        in  1    flush, only when not stalled
//   i_alu_operation_ff      in  clog2(ALU_OPS) opcode; UDIV/SDIV start the unit
//   i_cc_satisfied          in  1    condition passed
//   i_rn                    in  32   dividend, stable while o_busy
//   i_rm                    in  32   divisor, stable while o_busy
//   o_rd                    out 32   quotient in DONE, otherwise 0
//   o_busy                  out 1    unit occupied, upstream must hold
// -----------------------------------------------------------------------------
module zap_divide
    import zap_divide_pkg::*;
#(
    parameter int PHY_REGS = 46,
    parameter int ALU_OPS  = 32
)
(
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_clear_from_writeback,
    input  logic                        i_data_stall,
    input  logic                        i_clear_from_alu,
    input  logic [$clog2(ALU_OPS)-1:0]  i_alu_operation_ff,
    input  logic                        i_cc_satisfied,
    input  logic [31:0]                 i_rn,
    input  logic [31:0]                 i_rm,
    output logic [31:0]                 o_rd,
    output logic                        o_busy
);

    localparam int OPW = $clog2(ALU_OPS);

    // PHY_REGS only keeps the parameter list uniform with the multiplier.
    logic [31:0] unused_phy_regs;
    assign unused_phy_regs = 32'(PHY_REGS);

    div_state_t  state;
    logic [31:0] dvd;        // dividend magnitude, shifted out MSB first
    logic [31:0] dvsr;       // divisor magnitude
    logic [31:0] rem;        // partial remainder (always < dvsr after a step)
    logic [31:0] quot;       // quotient being assembled
    logic [4:0]  count;      // remaining ITER steps minus one
    logic        neg;        // quotient must be negated in FIXUP
    logic        signed_op;  // op captured at go is SDIV

    logic        is_udiv;
    logic        is_sdiv;
    logic        go;
    logic        flush;
    logic [31:0] abs_rn;
    logic [31:0] abs_rm;
    logic [32:0] rem_shift;
    logic [32:0] dvsr_ext;
    logic        take;

    assign is_udiv = (i_alu_operation_ff == OPW'(OP_UDIV));
    assign is_sdiv = (i_alu_operation_ff == OPW'(OP_SDIV));
    assign go      = (state == S_IDLE) && i_cc_satisfied && (is_udiv || is_sdiv);

    // Writeback flush overrides a stall; an ALU flush is held off by a stall.
    assign flush = !i_reset_n || i_clear_from_writeback ||
                   (!i_data_stall && i_clear_from_alu);

    // Operand magnitudes for INIT; UDIV passes the raw operands through.
    always_comb begin
        abs_rn = i_rn;
        abs_rm = i_rm;
        if (signed_op) begin
            abs_rn = magnitude(i_rn);
            abs_rm = magnitude(i_rm);
        end
    end

`ifdef ZAP_DIV_EARLY_TERM_EN
    logic [5:0] lead_zeros;

    zap_clz32 u_clz (
        .value (abs_rn),
        .count (lead_zeros)
    );
`endif

    // One restoring step on a 33-bit path: the shifted remainder can exceed
    // 32 bits when the divisor has its MSB set.
    always_comb begin
        rem_shift = {rem, dvd[31]};
        dvsr_ext  = {1'b0, dvsr};
        take      = (rem_shift >= dvsr_ext);
    end

    always_ff @(posedge i_clk) begin
        if (flush) begin
            state     <= S_IDLE;
            dvd       <= '0;
            dvsr      <= '0;
            rem       <= '0;
            quot      <= '0;
            count     <= '0;
            neg       <= 1'b0;
            signed_op <= 1'b0;
        end else if (!i_data_stall) begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        signed_op <= is_sdiv;
                        state     <= S_INIT;
                    end
                end

                S_INIT: begin
                    neg   <= signed_op && (i_rn[31] ^ i_rm[31]);
                    dvsr  <= abs_rm;
                    rem   <= '0;
                    quot  <= '0;
                    count <= 5'd31;
                    dvd   <= abs_rn;
                    if (abs_rm == 32'd0) begin
                        state <= S_DONE;
`ifdef ZAP_DIV_EARLY_TERM_EN
                    end else if (lead_zeros == 6'd32) begin
                        // Zero dividend: quotient is already 0.
                        state <= S_FIXUP;
                    end else begin
                        dvd   <= abs_rn << lead_zeros;
                        count <= 5'(6'd31 - lead_zeros);
                        state <= S_ITER;
                    end
`else
                    end else begin
                        state <= S_ITER;
                    end
`endif
                end

                S_ITER: begin
                    if (take) begin
                        rem  <= 32'(rem_shift - dvsr_ext);
                        quot <= {quot[30:0], 1'b1};
                    end else begin
                        rem  <= rem_shift[31:0];
                        quot <= {quot[30:0], 1'b0};
                    end
                    dvd   <= {dvd[30:0], 1'b0};
                    count <= count - 5'd1;
                    if (count == 5'd0) begin
                        state <= S_FIXUP;
                    end
                end

                S_FIXUP: begin
                    if (neg) begin
                        quot <= 32'(-quot);
                    end
                    state <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Busy rises in the go cycle itself so the issuing instruction is held.
    assign o_busy = go || (state == S_INIT) || (state == S_ITER) || (state == S_FIXUP);
    assign o_rd   = (state == S_DONE) ? quot : 32'd0;

endmodule

// File: tb/tb_zap_divide.sv
// -----------------------------------------------------------------------------
// tb_zap_divide
// Scoreboard bench for zap_divide. The driver issues divides (directed and
// random), pushing the expected quotient and expected busy-to-result latency;
// the monitor pops an entry whenever o_busy falls and checks o_rd and timing.
// Honours ZAP_DIV_EARLY_TERM_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_zap_divide;
    import zap_divide_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear_wb;
    logic        stall;
    logic        clear_alu;
    logic [4:0]  alu_op;
    logic        cc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] rd;
    logic        busy;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int          id;
        logic [31:0] q;
        int          go;
        int          lat;
    } exp_t;

    exp_t scb[$];
    int   next_id = 0;
    logic prev_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zap_divide #(.PHY_REGS(46), .ALU_OPS(32)) dut (
        .i_clk                  (clk),
        .i_reset_n              (reset_n),
        .i_clear_from_writeback (clear_wb),
        .i_data_stall           (stall),
        .i_clear_from_alu       (clear_alu),
        .i_alu_operation_ff     (alu_op),
        .i_cc_satisfied         (cc),
        .i_rn                   (rn),
        .i_rm                   (rm),
        .o_rd                   (rd),
        .o_busy                 (busy)
    );

    // Reference: plain integer division, truncating toward zero, result
    // reduced modulo 2^32; divide by zero gives 0.
    function automatic logic [31:0] model_q(input logic sdiv, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, q;
        if (b == 32'd0) return 32'd0;
        if (sdiv) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
        end else begin
            sa  = longint'({32'd0, a});
            sbv = longint'({32'd0, b});
        end
        q = sa / sbv;
        return q[31:0];
    endfunction

    // Cycles from the go cycle to the result cycle.
    function automatic int model_lat(input logic sdiv, input logic [31:0] a, input logic [31:0] b);
        longint mag;
        if (b == 32'd0) return 2;
`ifdef ZAP_DIV_EARLY_TERM_EN
        mag = (sdiv && a[31]) ? -longint'($signed(a)) : longint'({32'd0, a});
        return 3 + $clog2(mag + 1);   // 3 + number of significant bits
`else
        mag = 0;
        return 35 + int'(mag);
`endif
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a falling o_busy marks either a result (DONE) or an abort.
    always @(negedge clk) begin
        if (prev_busy && !busy) begin
            if (scb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got o_rd=0x%08h with empty scoreboard", rd);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check32($sformatf("op%0d_rd", e.id), rd, e.q);
                check_int($sformatf("op%0d_latency", e.id), cyc - e.go, e.lat);
            end
        end
        prev_busy = busy;
    end

    // abort_kind: 0 none, 1 clear_from_alu, 2 clear_from_writeback, 3 reset
    task automatic run_op(input logic sdiv, input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len,
                          input int abort_at, input int abort_kind, input int hold_done);
        exp_t e;
        bit   done = 0;
        e.id = next_id++;
        if (abort_kind != 0) begin
            e.q   = 32'd0;
            e.lat = abort_at + 1;
        end else begin
            e.q   = model_q(sdiv, a, b);
            e.lat = model_lat(sdiv, a, b) + stall_len;
        end
        @(posedge clk); #1;
        alu_op = sdiv ? 5'(OP_SDIV) : 5'(OP_UDIV);
        cc     = 1'b1;
        rn     = a;
        rm     = b;
        e.go   = cyc;
        scb.push_back(e);
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (!busy) begin
                done = 1;
                break;
            end
            stall     = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
            clear_alu = (abort_kind == 1) && (k == abort_at);
            clear_wb  = (abort_kind == 2) && (k == abort_at);
            reset_n   = !((abort_kind == 3) && (k == abort_at));
            if (abort_kind != 0 && k == abort_at) cc = 1'b0;
        end
        cc        = 1'b0;
        alu_op    = 5'd0;
        stall     = 1'b0;
        clear_alu = 1'b0;
        clear_wb  = 1'b0;
        reset_n   = 1'b1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL op%0d_timeout: busy still high after 200 cycles, expected release", e.id);
        end else if (hold_done > 0) begin
            stall = 1'b1;
            for (int h = 1; h <= hold_done; h++) begin
                @(posedge clk); #1;
                check32($sformatf("op%0d_hold_rd", e.id), rd, e.q);
                check32($sformatf("op%0d_hold_busy", e.id), {31'd0, busy}, 32'd0);
                if (h == hold_done) stall = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        clear_wb  = 1'b0;
        stall     = 1'b0;
        clear_alu = 1'b0;
        alu_op    = 5'd0;
        cc        = 1'b0;
        rn        = 32'd0;
        rm        = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_rd", rd, 32'd0);
        reset_n = 1'b1;

        // Directed cases
        run_op(1'b0, 32'd100, 32'd7, 0, 0, 0, 0, 0);
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0, 0, 0, 0, 0);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
        run_op(1'b0, 32'hDEADBEEF, 32'd0, 0, 0, 0, 0, 0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd1, 10, 5, 0, 0, 0);
        run_op(1'b0, 32'd5, 32'd2, 0, 0, 0, 0, 0);
        run_op(1'b0, 32'd0, 32'd9, 0, 0, 0, 0, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0, 0, 0, 0, 3);
        // Aborts: ALU clear, reset, writeback clear while stalled
        run_op(1'b0, 32'hFFFFFFFF, 32'd3, 0, 0, 12, 1, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd3, 0, 0, 15, 3, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'd3, 18, 5, 20, 2, 0);
        // Post-abort op must still produce a correct result
        run_op(1'b1, 32'd1000, 32'hFFFFFFF6, 0, 0, 0, 0, 0);

        // Failed condition: the unit must stay idle
        @(posedge clk); #1;
        alu_op = 5'(OP_UDIV);
        cc     = 1'b0;
        rn     = 32'd50;
        rm     = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check32("cc0_busy", {31'd0, busy}, 32'd0);
        end
        alu_op = 5'd0;

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            logic        sd;
            logic [31:0] a;
            logic [31:0] b;
            int          mode;
            int          slen;
            sd   = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'd0;
            else if (mode <= 3) b = 32'($urandom_range(1, 15));
            else if (mode == 4) a = 32'($urandom_range(0, 300));
            if (sd && mode <= 3 && $urandom_range(0, 1) == 1) b = 32'(-b);
            slen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_op(sd, a, b, 1, slen, 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check_int("scoreboard_drained", scb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zap_divide.md
Name: zap_divide

Overview:
Iterative 32/32 integer divider: radix-2 restoring, one quotient bit per cycle.
Sits in the shifter stage beside the multiplier and shares its control interface: clear, stall, ALU opcode, condition pass, and busy/result handshake.
Decodes UDIV (unsigned) and SDIV (signed, round toward zero) from the shared opcode set.
o_busy stalls the upstream pipeline until the result is presented.

Parameters:
PHY_REGS, 46, physical register count (interface uniformity only; unused internally)
ALU_OPS, 32, number of ALU opcodes; opcode width = clog2(ALU_OPS)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_clear_from_writeback  in  1  flush from writeback; highest priority after reset
i_data_stall  in  1  hold all state
i_clear_from_alu  in  1  flush from ALU
i_alu_operation_ff  in  clog2(ALU_OPS)  opcode; UDIV/SDIV start the unit
i_cc_satisfied  in  1  condition passed
i_rn  in  32  dividend; must stay stable while o_busy=1
i_rm  in  32  divisor; must stay stable while o_busy=1
o_rd  out  32  quotient, valid only in DONE, else 0
o_busy  out  1  unit occupied; pipeline must hold

Behaviour:
- Reset: clock and reset are one clock (i_clk) and a synchronous active-low reset (i_reset_n). Reset forces state=IDLE and clears quotient, remainder, counter and sign flag. o_busy=0, o_rd=0.
- Register-update priority: reset > clear_from_writeback (to IDLE, clear regs) > data_stall (hold everything) > clear_from_alu (to IDLE, clear regs) > normal advance.
- IDLE: o_busy=0.
  - If i_cc_satisfied and opcode is UDIV or SDIV: o_busy=1 in the same cycle, go to INIT.
- INIT:
  - Latch |dividend| and |divisor|; for UDIV the operands are taken raw.
  - Latch neg = SDIV & (rn[31]^rm[31]).
  - Clear remainder; set counter=31.
  - If divisor==0: quotient=0, go to DONE. This is ARM divide-by-zero semantics, no trap.
  - Otherwise go to ITER.
- ITER, per cycle:
  - rem' = {rem[31:0], dvd[31]} using a 33-bit subtract path; dvd <<= 1.
  - If rem' >= dvsr: rem = rem' - dvsr and shift in quotient bit 1; otherwise rem = rem' and shift in 0.
  - counter-1; when counter==0, go to FIXUP.
- FIXUP: if neg, quotient = -quotient (two's complement, 32-bit wrap). Go to DONE.
- DONE: o_busy=0, o_rd=quotient, go to IDLE. o_rd is combinational from state and is 0 in every other state.
- Latency without the feature: go cycle + INIT + 32 ITER + FIXUP + DONE. Result appears on the 35th edge after the go cycle. Divide-by-zero result appears 2 edges after go.
- SDIV 0x80000000 / 0xFFFFFFFF yields 0x80000000, from the natural 32-bit wrap of abs and negate; no special case.
- A stall during DONE holds o_rd valid and o_busy=0 until the stall releases.
- A clear in any state aborts with no result produced.
- A new go is accepted only in IDLE; back-to-back ops cost one IDLE cycle.

Optional Feature:
ZAP_DIV_EARLY_TERM_EN
- With the macro: INIT computes the leading-zero count L of |dividend|, pre-shifts the dividend left by L, and sets counter = 31-L.
- Dividend==0 with nonzero divisor goes straight to FIXUP.
- Quotient is identical to the full run; latency = 3 + (32-L) cycles after go.
- Without the macro: a fixed 32 ITER cycles, and no leading-zero logic is synthesized.

Decomposition:
- Package/shared header (opcodes.vh): UDIV and SDIV opcode constants, alongside the existing multiply opcodes.
- State encodings: local constants (IDLE, INIT, ITER, FIXUP, DONE).
- One natural sub-module: zap_clz32, a combinational 32-bit leading-zero counter, instantiated only under ZAP_DIV_EARLY_TERM_EN.

Test Plan:
- UDIV rn=100, rm=7, cc=1 → o_busy high 35 cycles; DONE shows o_rd=14, o_busy=0; then IDLE.
- SDIV rn=0xFFFFFF9C (-100), rm=7 → o_rd=0xFFFFFFF2 (-14). Also rn=7, rm=-2 → 0xFFFFFFFD (-3).
- UDIV rn=0xDEADBEEF, rm=0 → DONE 2 cycles after go with o_rd=0. SDIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- UDIV 0xFFFFFFFF / 1 with i_data_stall asserted for 5 cycles mid-ITER → completion delayed by exactly 5 cycles; o_rd=0xFFFFFFFF.
- Assert i_clear_from_alu in ITER cycle 10 → IDLE next cycle, o_busy=0, no DONE. Repeat with i_reset_n=0 mid-op → all regs cleared. With cc=0 and opcode UDIV → never leaves IDLE.
- With ZAP_DIV_EARLY_TERM_EN: UDIV 5/2 → o_rd=2 in 3+3=6 cycles after go. UDIV 0/9 → o_rd=0, path INIT→FIXUP→DONE.
